// File: rtl/bus_dec_pkg.sv
// Shared types and helpers for the CPU bus decoder: FSM states, fault status
// layout and error-window word offsets.
package bus_dec_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ERR  = 1'b1
  } state_t;

  // Low three bits of error-window word 1
  typedef struct packed {
    logic we;
    logic tmo;
    logic unm;
  } flt_stat_t;

  localparam logic ERR_WORD_ADDR = 1'b0;
  localparam logic ERR_WORD_STAT = 1'b1;

  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
    return (v == '1) ? v : v + EW'(1);
  endfunction

  function automatic logic [DW-1:0] stat_word(input logic [EW-1:0] cnt, input flt_stat_t st);
    return {16'h0, cnt, 5'b0, st};
  endfunction

endpackage

// File: rtl/bus_dec_if.sv
// CPU-side bus of the decoder: the CPU is master, bus_dec is slave.
interface bus_dec_if #(
  parameter int unsigned AW = 22
) ();

  logic          bus_stb;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdat;
  logic [31:0]   bus_din;
  logic          bus_ack;

  modport master (output bus_stb, bus_we, bus_addr, bus_wdat, input bus_din, bus_ack);
  modport slave  (input bus_stb, bus_we, bus_addr, bus_wdat, output bus_din, bus_ack);

endinterface

// File: rtl/bus_tmo.sv
// Ack wait counter: counts while enabled, clears on request, flags the last
// cycle before a timeout.
module bus_tmo #(
  parameter int unsigned TMO_CYC = 255,
  parameter int unsigned CW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_c = (cnt_q == CW'(TMO_CYC - 1));

endmodule

// File: rtl/bus_dec.sv
// CPU bus decoder/mux for NSLV slaves with timeout/unmapped termination and a
// two-word fault window with sticky interrupt.
module bus_dec
  import bus_dec_pkg::*;
#(
  parameter int unsigned           NSLV     = 8,
  parameter int unsigned           AW       = 22,
  parameter logic [NSLV*AW-1:0]    SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0]    SLV_MASK = '1,
  parameter logic [AW-1:0]         ERR_BASE = AW'(22'h3FFFE8),
  parameter int unsigned           TMO_CYC  = 255,
  parameter int unsigned           CW       = 8
) (
  input  logic               clk,
  input  logic               rst,
  bus_dec_if.slave           bus,
  output logic [NSLV-1:0]    slv_stb,
  input  logic [NSLV*32-1:0] slv_dout,
  input  logic [NSLV-1:0]    slv_ack,
  output logic               err_irq
);

  state_t         state_q, state_d;
  logic           cause_tmo_q, cause_tmo_d;
  logic [AW-1:0]  flt_addr_q, flt_addr_d;
  flt_stat_t      flt_stat_q, flt_stat_d;
  logic [EW-1:0]  cnt_err_q, cnt_err_d;
  logic           err_irq_q, err_irq_d;

  logic            err_hit, slv_found, sel_ack;
  logic [NSLV-1:0] slv_sel;
  logic [DW-1:0]   sel_dat, win_rdat;
  logic            idle, slv_req, unm_req, win_req, slv_done, tmo_hit, clr_req;
  logic            tmo_en, tmo_term_c;
  logic            unused_wdat;

  // Address decode: error window first, then lowest-index matching slave
  always_comb begin
    err_hit   = (bus.bus_addr[AW-1:1] == ERR_BASE[AW-1:1]);
    slv_found = 1'b0;
    slv_sel   = '0;
    sel_dat   = '0;
    sel_ack   = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!slv_found && ((bus.bus_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        slv_found  = 1'b1;
        slv_sel[i] = 1'b1;
        sel_dat    = slv_dout[i*32 +: 32];
        sel_ack    = slv_ack[i];
      end
    end
  end

  always_comb begin
    idle     = (state_q == ST_IDLE);
    win_req  = bus.bus_stb & idle & err_hit;
    slv_req  = bus.bus_stb & idle & !err_hit & slv_found;
    unm_req  = bus.bus_stb & idle & !err_hit & !slv_found;
    slv_done = slv_req & sel_ack;
    tmo_en   = slv_req & !sel_ack;
    tmo_hit  = tmo_en & tmo_term_c;
    clr_req  = win_req & bus.bus_we & (bus.bus_addr[0] == ERR_WORD_STAT);
    win_rdat = (bus.bus_addr[0] == ERR_WORD_STAT) ? stat_word(cnt_err_q, flt_stat_q)
                                                  : DW'({flt_addr_q, 2'b00});
    slv_stb     = slv_req ? slv_sel : '0;
    bus.bus_ack = !idle | win_req | slv_done;
    bus.bus_din = win_req ? win_rdat : (slv_req ? sel_dat : '0);
  end

  assign unused_wdat = ^bus.bus_wdat;

  bus_tmo #(
    .TMO_CYC (TMO_CYC),
    .CW      (CW)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (!tmo_en | tmo_term_c),
    .en     (tmo_en),
    .term_c (tmo_term_c)
  );

  // A fault entry takes precedence over a pending status clear
  always_comb begin
    state_d     = state_q;
    cause_tmo_d = cause_tmo_q;
    flt_addr_d  = flt_addr_q;
    flt_stat_d  = flt_stat_q;
    cnt_err_d   = cnt_err_q;
    err_irq_d   = err_irq_q;
    case (state_q)
      ST_IDLE: begin
        if (unm_req || tmo_hit) begin
          state_d     = ST_ERR;
          cause_tmo_d = tmo_hit;
        end else if (clr_req) begin
          err_irq_d      = 1'b0;
          flt_stat_d.tmo = 1'b0;
          flt_stat_d.unm = 1'b0;
        end
      end
      ST_ERR: begin
        state_d        = ST_IDLE;
        flt_addr_d     = bus.bus_addr;
        flt_stat_d.we  = bus.bus_we;
        flt_stat_d.tmo = cause_tmo_q;
        flt_stat_d.unm = !cause_tmo_q;
        cnt_err_d      = sat_inc(cnt_err_q);
        err_irq_d      = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cause_tmo_q <= 1'b0;
      flt_addr_q  <= '0;
      flt_stat_q  <= '0;
      cnt_err_q   <= '0;
      err_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_tmo_q <= cause_tmo_d;
      flt_addr_q  <= flt_addr_d;
      flt_stat_q  <= flt_stat_d;
      cnt_err_q   <= cnt_err_d;
      err_irq_q   <= err_irq_d;
    end
  end

  assign err_irq = err_irq_q;

endmodule
